mem_port_arbiter: RTL and testbench

- Shares the single 128-bit block memory port between two cache masters: port 0 (instruction cache) and port 1 (data cache).
- Both master ports use the same request interface the caches already drive: 12-bit block address, rw, valid held until ready, and a 128-bit block.
- Grants one master at a time and holds the grant for one whole memory transaction.
- Detects a memory that never answers and releases the port.

---
 rtl/mem_port_arbiter.sv | 127 ++++++++++++
 tb/tb_mem_port_arbiter.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Shares one 128-bit block-memory port between the I-cache (port 0) and the D-cache (port 1).
// Define ARB_ROUND_ROBIN_EN for round-robin on simultaneous requests; otherwise port 1 has fixed priority.
module mem_port_arbiter #(
   parameter int ADDR_W  = 12,
   parameter int BLK_W   = 128,
   parameter int TIMEOUT = 255
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] m0_req_addr,
   input  logic              m0_req_rw,
   input  logic              m0_req_valid,
   input  logic [BLK_W-1:0]  m0_data_write,
   output logic [BLK_W-1:0]  m0_data_read,
   output logic              m0_ready,
   input  logic [ADDR_W-1:0] m1_req_addr,
   input  logic              m1_req_rw,
   input  logic              m1_req_valid,
   input  logic [BLK_W-1:0]  m1_data_write,
   output logic [BLK_W-1:0]  m1_data_read,
   output logic              m1_ready,
   output logic [ADDR_W-1:0] mem_req_addr,
   output logic              mem_req_rw,
   output logic              mem_req_valid,
   output logic [BLK_W-1:0]  mem_data_write,
   input  logic [BLK_W-1:0]  mem_data_read,
   input  logic              mem_ready,
   output logic [1:0]        grant,
   output logic              timeout_err
);

   typedef enum logic [1:0] {IDLE, BUSY, RELEASE} state_t;

   localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

   state_t     state_q, state_d;
   logic       owner_q, owner_d;
   logic [7:0] wait_cnt_q, wait_cnt_d;
   logic       timeout_err_q, timeout_err_d;
   logic       busy;
   logic       own_valid;
   logic       winner;

   assign busy      = (state_q == BUSY);
   assign own_valid = owner_q ? m1_req_valid : m0_req_valid;

`ifdef ARB_ROUND_ROBIN_EN
   logic last_grant_q, last_grant_d;

   // On a tie the port that did not win last time goes first.
   always_comb begin
      winner = m1_req_valid;
      if (m0_req_valid && m1_req_valid) winner = ~last_grant_q;
   end

   always_comb begin
      last_grant_d = last_grant_q;
      if (state_q == IDLE && (m0_req_valid || m1_req_valid)) last_grant_d = winner;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) last_grant_q <= 1'b1;
      else     last_grant_q <= last_grant_d;
   end
`else
   assign winner = m1_req_valid;
`endif

   always_comb begin
      state_d       = state_q;
      owner_d       = owner_q;
      wait_cnt_d    = wait_cnt_q;
      timeout_err_d = timeout_err_q;
      case (state_q)
         IDLE: begin
            if (m0_req_valid || m1_req_valid) begin
               state_d    = BUSY;
               owner_d    = winner;
               wait_cnt_d = '0;
            end
         end
         BUSY: begin
            if (mem_ready) begin
               state_d = RELEASE;
            end else if (!own_valid) begin
               state_d = IDLE;
            end else if (wait_cnt_q == WAIT_LAST) begin
               // Memory never answered: flag it and free the port.
               timeout_err_d = 1'b1;
               state_d       = RELEASE;
            end else if (wait_cnt_q != 8'hFF) begin
               wait_cnt_d = wait_cnt_q + 8'd1;
            end
         end
         RELEASE: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= IDLE;
         owner_q       <= 1'b0;
         wait_cnt_q    <= '0;
         timeout_err_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         owner_q       <= owner_d;
         wait_cnt_q    <= wait_cnt_d;
         timeout_err_q <= timeout_err_d;
      end
   end

   // Memory side is a pure mux so a request reaches memory the cycle the grant starts.
   assign grant          = busy ? (owner_q ? 2'b10 : 2'b01) : 2'b00;
   assign mem_req_valid  = busy & own_valid;
   assign mem_req_addr   = busy ? (owner_q ? m1_req_addr : m0_req_addr) : '0;
   assign mem_req_rw     = busy & (owner_q ? m1_req_rw : m0_req_rw);
   assign mem_data_write = busy ? (owner_q ? m1_data_write : m0_data_write) : '0;

   assign m0_data_read = mem_data_read;
   assign m1_data_read = mem_data_read;
   assign m0_ready     = mem_ready & busy & ~owner_q;
   assign m1_ready     = mem_ready & busy & owner_q;
   assign timeout_err  = timeout_err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed arbitration/timeout/reset cases, then randomized
// traffic scored against a per-master memory model.
module tb_mem_port_arbiter;

   logic         clk;
   logic         rst;
   logic [11:0]  m0_req_addr, m1_req_addr;
   logic         m0_req_rw, m1_req_rw;
   logic         m0_req_valid, m1_req_valid;
   logic [127:0] m0_data_write, m1_data_write;
   logic [127:0] m0_data_read, m1_data_read;
   logic         m0_ready, m1_ready;
   logic [11:0]  mem_req_addr;
   logic         mem_req_rw;
   logic         mem_req_valid;
   logic [127:0] mem_data_write;
   logic [127:0] mem_data_read;
   logic         mem_ready;
   logic [1:0]   grant;
   logic         timeout_err;

   mem_port_arbiter dut (
      .clk(clk), .rst(rst),
      .m0_req_addr(m0_req_addr), .m0_req_rw(m0_req_rw), .m0_req_valid(m0_req_valid),
      .m0_data_write(m0_data_write), .m0_data_read(m0_data_read), .m0_ready(m0_ready),
      .m1_req_addr(m1_req_addr), .m1_req_rw(m1_req_rw), .m1_req_valid(m1_req_valid),
      .m1_data_write(m1_data_write), .m1_data_read(m1_data_read), .m1_ready(m1_ready),
      .mem_req_addr(mem_req_addr), .mem_req_rw(mem_req_rw), .mem_req_valid(mem_req_valid),
      .mem_data_write(mem_data_write), .mem_data_read(mem_data_read), .mem_ready(mem_ready),
      .grant(grant), .timeout_err(timeout_err)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   typedef struct {
      logic [11:0]  addr;
      logic         rw;
      logic [127:0] wdata;
      logic [127:0] rdata;
   } txn_t;

   int           n_checks = 0;
   int           n_pass   = 0;
   bit           sb_en    = 1'b0;
   bit           rand_done = 1'b0;
   txn_t         exp_q0[$];
   txn_t         exp_q1[$];
   logic [127:0] ref_mem [2][16];
   logic [127:0] store [logic [11:0]];

   function automatic logic [127:0] init_blk(input logic [11:0] a);
      return {4{20'hA5A5A, a}};
   endfunction

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Called one tick into a BUSY cycle; answers it and ends one tick into RELEASE.
   task automatic serve(input string tag, input logic [1:0] g, input logic [11:0] a,
                        input logic rw, input logic [127:0] rdata);
      chk({tag, "_grant"}, 128'(grant), 128'(g));
      chk({tag, "_addr"}, 128'(mem_req_addr), 128'(a));
      chk({tag, "_rw"}, 128'(mem_req_rw), 128'(rw));
      mem_data_read = rdata;
      mem_ready     = 1'b1;
      #1;
      chk({tag, "_ready"}, 128'({m1_ready, m0_ready}), 128'(g));
      chk({tag, "_rdata"}, g[1] ? m1_data_read : m0_data_read, rdata);
      step();
      mem_ready     = 1'b0;
      mem_data_read = '0;
      chk({tag, "_release"}, 128'(grant), 128'(0));
   endtask

   task automatic set_req(input int p, input logic v, input logic [11:0] a,
                          input logic rw, input logic [127:0] wd);
      if (p == 0) begin
         m0_req_valid = v; m0_req_addr = a; m0_req_rw = rw; m0_data_write = wd;
      end else begin
         m1_req_valid = v; m1_req_addr = a; m1_req_rw = rw; m1_data_write = wd;
      end
   endtask

   task automatic drive(input int p, input int n);
      txn_t t;
      int   b;
      for (int i = 0; i < n; i++) begin
         t.addr  = {(p == 0) ? 8'h0C : 8'h0D, 4'($urandom)};
         t.rw    = 1'($urandom_range(0, 1));
         t.wdata = {$urandom, $urandom, $urandom, $urandom};
         t.rdata = '0;
         if (t.rw) ref_mem[p][t.addr[3:0]] = t.wdata;
         else      t.rdata = ref_mem[p][t.addr[3:0]];
         if (p == 0) exp_q0.push_back(t);
         else        exp_q1.push_back(t);
         set_req(p, 1'b1, t.addr, t.rw, t.wdata);
         b = 0;
         do begin
            @(negedge clk);
            b++;
         end while (!((p == 0) ? m0_ready : m1_ready) && b < 2000);
         if (!((p == 0) ? m0_ready : m1_ready)) begin
            n_checks++;
            $display("FAIL m%0d_wait_ready: no ready after %0d cycles, required within 2000", p, b);
            set_req(p, 1'b0, '0, 1'b0, '0);
            return;
         end
         step();
         set_req(p, 1'b0, '0, 1'b0, '0);
         repeat ($urandom_range(0, 2)) step();
      end
   endtask

   task automatic responder();
      logic [11:0] a;
      while (!rand_done) begin
         step();
         if (mem_req_valid) begin
            repeat ($urandom_range(0, 4)) step();
            a = mem_req_addr;
            if (mem_req_rw) begin
               store[a]      = mem_data_write;
               mem_data_read = {$urandom, $urandom, $urandom, $urandom};
            end else begin
               mem_data_read = store.exists(a) ? store[a] : init_blk(a);
            end
            mem_ready = 1'b1;
            step();
            mem_ready     = 1'b0;
            mem_data_read = '0;
         end
      end
   endtask

   task automatic pop_check(input int p);
      txn_t t;
      if ((p == 0 && exp_q0.size() == 0) || (p == 1 && exp_q1.size() == 0)) begin
         n_checks++;
         $display("FAIL m%0d_spurious_ready: ready with no outstanding request, required none", p);
         return;
      end
      t = (p == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
      chk($sformatf("sb_m%0d_addr", p), 128'(mem_req_addr), 128'(t.addr));
      chk($sformatf("sb_m%0d_rw", p), 128'(mem_req_rw), 128'(t.rw));
      if (t.rw) chk($sformatf("sb_m%0d_wdata", p), mem_data_write, t.wdata);
      else      chk($sformatf("sb_m%0d_rdata", p), (p == 0) ? m0_data_read : m1_data_read, t.rdata);
   endtask

   // Monitor: any ready must belong to the current owner; scoreboard pops during random traffic.
   initial begin
      forever begin
         @(negedge clk);
         if (m0_ready || m1_ready) chk("ready_vs_grant", 128'({m1_ready, m0_ready}), 128'(grant));
         if (sb_en && m0_ready) pop_check(0);
         if (sb_en && m1_ready) pop_check(1);
      end
   end

   initial begin
      logic [1:0] cont_g [4];
      rst = 1'b1;
      mem_ready = 1'b0;
      mem_data_read = '0;
      set_req(0, 1'b0, '0, 1'b0, '0);
      set_req(1, 1'b0, '0, 1'b0, '0);
      #3;
      chk("rst_grant", 128'(grant), 128'(0));
      chk("rst_mem_valid", 128'(mem_req_valid), 128'(0));
      chk("rst_timeout_err", 128'(timeout_err), 128'(0));
      repeat (2) @(negedge clk);
      rst = 1'b0;
      step();

      // Both ports held valid over four transactions.
`ifdef ARB_ROUND_ROBIN_EN
      cont_g = '{2'b01, 2'b10, 2'b01, 2'b10};
`else
      cont_g = '{2'b10, 2'b10, 2'b10, 2'b10};
`endif
      set_req(0, 1'b1, 12'h101, 1'b0, '0);
      set_req(1, 1'b1, 12'h202, 1'b0, '0);
      for (int k = 0; k < 4; k++) begin
         step();
         serve($sformatf("cont%0d", k), cont_g[k], (cont_g[k] == 2'b01) ? 12'h101 : 12'h202,
               1'b0, {$urandom, $urandom, $urandom, $urandom});
         if (k == 3) begin
            set_req(0, 1'b0, '0, 1'b0, '0);
            set_req(1, 1'b0, '0, 1'b0, '0);
         end
         step();
      end

      // Single read from port 0 with a three-cycle memory.
      set_req(0, 1'b1, 12'h0A4, 1'b0, '0);
      #1;
      chk("t1_idle_valid", 128'(mem_req_valid), 128'(0));
      chk("t1_idle_addr", 128'(mem_req_addr), 128'(0));
      step();
      chk("t1_busy_valid", 128'(mem_req_valid), 128'(1));
      for (int k = 0; k < 3; k++) begin
         step();
         chk($sformatf("t1_wait%0d", k), 128'({m1_ready, m0_ready, grant}), 128'(4'b0001));
      end
      serve("t1", 2'b01, 12'h0A4, 1'b0, {32{4'h1}});
      set_req(0, 1'b0, '0, 1'b0, '0);
      step();
      chk("t1_idle_grant", 128'(grant), 128'(0));

      // Simultaneous requests: port 1 first, port 0 after RELEASE and IDLE.
      set_req(0, 1'b1, 12'h010, 1'b0, '0);
      set_req(1, 1'b1, 12'h020, 1'b0, '0);
      step();
      serve("t2a", 2'b10, 12'h020, 1'b0, {4{32'h2222_0020}});
      set_req(1, 1'b0, '0, 1'b0, '0);
      step();
      chk("t2_gap_grant", 128'(grant), 128'(0));
      step();
      serve("t2b", 2'b01, 12'h010, 1'b0, {4{32'h2222_0010}});
      set_req(0, 1'b0, '0, 1'b0, '0);
      step();

      // Writeback then allocate from port 1 while port 0 waits.
      set_req(0, 1'b1, 12'h055, 1'b0, '0);
      set_req(1, 1'b1, 12'h380, 1'b1, {4{32'hDEADBEEF}});
      step();
      chk("t3_wdata", mem_data_write, {4{32'hDEADBEEF}});
      serve("t3wr", 2'b10, 12'h380, 1'b1, '0);
      set_req(1, 1'b1, 12'h384, 1'b0, '0);
      step();
      step();
`ifdef ARB_ROUND_ROBIN_EN
      serve("t3m0", 2'b01, 12'h055, 1'b0, {4{32'h3333_0055}});
      set_req(0, 1'b0, '0, 1'b0, '0);
      step();
      step();
      serve("t3rd", 2'b10, 12'h384, 1'b0, {4{32'h3333_0384}});
      set_req(1, 1'b0, '0, 1'b0, '0);
`else
      serve("t3rd", 2'b10, 12'h384, 1'b0, {4{32'h3333_0384}});
      set_req(1, 1'b0, '0, 1'b0, '0);
      step();
      step();
      serve("t3m0", 2'b01, 12'h055, 1'b0, {4{32'h3333_0055}});
      set_req(0, 1'b0, '0, 1'b0, '0);
`endif
      step();

      // Memory never answers port 0.
      set_req(0, 1'b1, 12'h0F0, 1'b0, '0);
      step();
      repeat (254) step();
      chk("t4_last_busy", 128'({timeout_err, grant}), 128'(3'b001));
      step();
      chk("t4_abort", 128'({timeout_err, grant}), 128'(3'b100));
      set_req(0, 1'b0, '0, 1'b0, '0);
      step();
      set_req(1, 1'b1, 12'h222, 1'b0, '0);
      step();
      serve("t4m1", 2'b10, 12'h222, 1'b0, {4{32'h4444_0222}});
      set_req(1, 1'b0, '0, 1'b0, '0);
      chk("t4_sticky", 128'(timeout_err), 128'(1));
      step();

      // Asynchronous reset in the middle of a grant.
      set_req(0, 1'b1, 12'h033, 1'b0, '0);
      step();
      chk("t5_busy_valid", 128'(mem_req_valid), 128'(1));
      #2;
      rst = 1'b1;
      #1;
      chk("t5_async", 128'({timeout_err, mem_req_valid, grant}), 128'(0));
      set_req(0, 1'b0, '0, 1'b0, '0);
      @(negedge clk);
      rst = 1'b0;
      step();
      mem_ready = 1'b1;
      #1;
      chk("t5_stray_ready", 128'({m1_ready, m0_ready}), 128'(0));
      step();
      mem_ready = 1'b0;

      // Randomized traffic from both masters.
      for (int p = 0; p < 2; p++)
         for (int i = 0; i < 16; i++)
            ref_mem[p][i] = init_blk({(p == 0) ? 8'h0C : 8'h0D, 4'(i)});
      sb_en = 1'b1;
      fork
         begin
            fork
               drive(0, 40);
               drive(1, 40);
            join
            rand_done = 1'b1;
         end
         responder();
      join
      repeat (3) step();
      chk("sb_q0_empty", 128'(exp_q0.size()), 128'(0));
      chk("sb_q1_empty", 128'(exp_q1.size()), 128'(0));

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
